// File: rtl/sdmac_bus_pkg.sv
// Shared definitions for the SDMAC 68030 bus target: FSM encoding, DSACK codes, counter widths.
package sdmac_bus_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned TO_CNT_W   = 8;
  localparam int unsigned WAIT_CNT_W = 3;

  // Bus-cycle FSM states
  localparam logic [STATE_W-1:0] IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ACCESS = 2'd1;
  localparam logic [STATE_W-1:0] TERM   = 2'd2;
  localparam logic [STATE_W-1:0] BERR   = 2'd3;

  // _DSACK encodings (active low)
  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  // Register-window decode
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/sdmac_bus_target_if.sv
// 68030 bus pins plus the register-bank REQ/ACK port seen by the SDMAC bus target.
interface sdmac_bus_target_if #(
  parameter int unsigned REG_AW = 6
);
  // 68030 side
  logic [31:0]       addr;
  logic              as_n;
  logic              ds_n;
  logic              rw;
  logic [31:0]       data_i;
  logic [31:0]       data_o;
  logic              data_oe;
  logic [1:0]        dsack_n;
  logic              berr_n;
  // Register-bank side
  logic [REG_AW-1:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic              reg_rd;
  logic              reg_wr;
  logic [31:0]       reg_rdata;
  logic              reg_ack;

  modport slave (
    input  addr, as_n, ds_n, rw, data_i, reg_rdata, reg_ack,
    output data_o, data_oe, dsack_n, berr_n, reg_addr, reg_wdata, reg_rd, reg_wr
  );

  modport master (
    output addr, as_n, ds_n, rw, data_i, reg_rdata, reg_ack,
    input  data_o, data_oe, dsack_n, berr_n, reg_addr, reg_wdata, reg_rd, reg_wr
  );

endinterface

// File: rtl/sdmac_sync2.sv
// Two-flop synchroniser for an asynchronous active-low strobe; resets to the idle (1) level.
module sdmac_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability filter: two back-to-back flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sdmac_bus_target.sv
// 68030 asynchronous bus slave for the SDMAC register window: synchronises _AS/_DS,
// decodes the window, runs a REQ/ACK handshake to the register bank and terminates
// with a 32-bit _DSACK or, on backend timeout, _BERR.
module sdmac_bus_target
  import sdmac_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h00DD_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_0000,
  parameter int unsigned REG_AW      = 6,
  parameter int unsigned TIMEOUT     = 64,   // 1..255
  parameter int unsigned DSACK_DELAY = 1     // 0..7
) (
  input  logic               clk,
  input  logic               rst_n,
  sdmac_bus_target_if.slave  bus
);

  logic                  as_s;
  logic                  ds_s;

  logic [STATE_W-1:0]    state_q,     state_d;
  logic                  armed_q,     armed_d;
  logic                  rw_q,        rw_d;
  logic [TO_CNT_W-1:0]   to_cnt_q,    to_cnt_d;
  logic [WAIT_CNT_W-1:0] wait_q,      wait_d;
  logic [31:0]           data_o_q,    data_o_d;
  logic                  data_oe_q,   data_oe_d;
  logic [1:0]            dsack_q,     dsack_d;
  logic                  berr_q,      berr_d;
  logic [REG_AW-1:0]     reg_addr_q,  reg_addr_d;
  logic [31:0]           reg_wdata_q, reg_wdata_d;
  logic                  reg_rd_q,    reg_rd_d;
  logic                  reg_wr_q,    reg_wr_d;

  // Strobe synchronisers
  sdmac_sync2 u_sync_as (.clk(clk), .rst_n(rst_n), .d_i(bus.as_n), .q_o(as_s));
  sdmac_sync2 u_sync_ds (.clk(clk), .rst_n(rst_n), .d_i(bus.ds_n), .q_o(ds_s));

  // Next-state and registered-output logic for the bus cycle
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    rw_d        = rw_q;
    to_cnt_d    = to_cnt_q;
    wait_d      = wait_q;
    data_o_d    = data_o_q;
    data_oe_d   = data_oe_q;
    dsack_d     = dsack_q;
    berr_d      = berr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_rd_d    = reg_rd_q;
    reg_wr_d    = reg_wr_q;

    // Any _AS negation re-arms decode after a missed cycle
    if (as_s) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        // ADDR/RW/DATA_I are stable long before the synchronised strobes arrive
        if (armed_q && !as_s && !ds_s) begin
          if (addr_hit(bus.addr, BASE_ADDR, ADDR_MASK)) begin
            reg_addr_d  = bus.addr[REG_AW+1:2];
            rw_d        = bus.rw;
            reg_wdata_d = bus.data_i;
            reg_rd_d    = bus.rw;
            reg_wr_d    = ~bus.rw;
            to_cnt_d    = '0;
            state_d     = ACCESS;
          end else begin
            armed_d = 1'b0;
          end
        end
      end

      ACCESS: begin
        // REG_ACK has priority over both abort and timeout
        if (bus.reg_ack) begin
          reg_rd_d  = 1'b0;
          reg_wr_d  = 1'b0;
          if (rw_q) begin
            data_o_d = bus.reg_rdata;
          end
          data_oe_d = rw_q;
          wait_d    = WAIT_CNT_W'(DSACK_DELAY);
          if (DSACK_DELAY == 0) begin
            dsack_d = DSACK_32;
          end
          state_d   = TERM;
        end else if (as_s) begin
          reg_rd_d = 1'b0;
          reg_wr_d = 1'b0;
          state_d  = IDLE;
        end else if (to_cnt_q == TO_CNT_W'(TIMEOUT - 1)) begin
          reg_rd_d = 1'b0;
          reg_wr_d = 1'b0;
          berr_d   = 1'b0;
          state_d  = BERR;
        end else begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end
      end

      TERM: begin
        // Master negation ends the cycle even while the delay is still counting
        if (as_s) begin
          dsack_d   = DSACK_NONE;
          data_oe_d = 1'b0;
          state_d   = IDLE;
        end else if (wait_q > WAIT_CNT_W'(1)) begin
          wait_d = wait_q - WAIT_CNT_W'(1);
        end else begin
          wait_d  = '0;
          dsack_d = DSACK_32;
        end
      end

      BERR: begin
        if (as_s) begin
          berr_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, counters and bus/register outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= 1'b1;
      rw_q        <= 1'b0;
      to_cnt_q    <= '0;
      wait_q      <= '0;
      data_o_q    <= '0;
      data_oe_q   <= 1'b0;
      dsack_q     <= DSACK_NONE;
      berr_q      <= 1'b1;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
    end else begin
      armed_q     <= armed_d;
      rw_q        <= rw_d;
      to_cnt_q    <= to_cnt_d;
      wait_q      <= wait_d;
      data_o_q    <= data_o_d;
      data_oe_q   <= data_oe_d;
      dsack_q     <= dsack_d;
      berr_q      <= berr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_rd_q    <= reg_rd_d;
      reg_wr_q    <= reg_wr_d;
    end
  end

  assign bus.data_o    = data_o_q;
  assign bus.data_oe   = data_oe_q;
  assign bus.dsack_n   = dsack_q;
  assign bus.berr_n    = berr_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.reg_wr    = reg_wr_q;

endmodule

// File: tb/tb_sdmac_bus_target.sv
// Bench for sdmac_bus_target: table of bus cycles, scoreboard of expected terminations,
// plus hand-written abort and reset-mid-TERM sequences.
module tb_sdmac_bus_target;

  localparam int unsigned DSACK_DELAY = 1;
  localparam int unsigned TIMEOUT     = 64;
  localparam int          NVEC        = 9;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;   // edges after REG_RD/WR before ACK is raised; <0 = never
  } vec_t;

  typedef struct {
    logic        berr;
    logic [5:0]  reg_addr;
    logic        rw;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  exp_t exp_q[$];
  vec_t vecs[NVEC];

  sdmac_bus_target_if #(.REG_AW(6)) bus ();

  sdmac_bus_target #(
    .BASE_ADDR  (32'h00DD_0000),
    .ADDR_MASK  (32'hFFFF_0000),
    .REG_AW     (6),
    .TIMEOUT    (TIMEOUT),
    .DSACK_DELAY(DSACK_DELAY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: capture the request, pop and compare the scoreboard at each termination
  logic [5:0]  obs_addr;
  logic        obs_rd;
  logic        obs_wr;
  logic [31:0] obs_wdata;
  logic        prev_req;
  logic [1:0]  prev_dsack;
  logic        prev_berr;
  exp_t        mon_e;
  logic        obs_kind;

  initial begin
    prev_req   = 1'b0;
    prev_dsack = 2'b11;
    prev_berr  = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!prev_req && (bus.reg_rd || bus.reg_wr)) begin
        obs_addr  = bus.reg_addr;
        obs_rd    = bus.reg_rd;
        obs_wr    = bus.reg_wr;
        obs_wdata = bus.reg_wdata;
      end
      if ((prev_dsack != 2'b00 && bus.dsack_n == 2'b00) || (prev_berr && !bus.berr_n)) begin
        obs_kind = ~bus.berr_n;
        chk("term_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("term_kind", 32'(obs_kind), 32'(mon_e.berr));
          chk("reg_addr", 32'(obs_addr), 32'(mon_e.reg_addr));
          chk("req_type", 32'({obs_rd, obs_wr}), mon_e.rw ? 32'd2 : 32'd1);
          if (!mon_e.rw) chk("reg_wdata", obs_wdata, mon_e.wdata);
          if (mon_e.rw && !mon_e.berr) chk("data_o", bus.data_o, mon_e.rdata);
          chk("data_oe", 32'(bus.data_oe), 32'(mon_e.rw & ~mon_e.berr));
        end
      end
    end
    prev_req   = bus.reg_rd | bus.reg_wr;
    prev_dsack = bus.dsack_n;
    prev_berr  = bus.berr_n;
  end

  // Runs one complete bus cycle from the table
  task automatic run_vec(input vec_t v);
    bit   hit;
    bit   ok;
    int   n;
    exp_t e;
    hit = ((v.addr & 32'hFFFF_0000) == 32'h00DD_0000);
    if (hit) begin
      e.berr     = (v.ack_dly < 0);
      e.reg_addr = v.addr[7:2];
      e.rw       = v.rw;
      e.wdata    = v.wdata;
      e.rdata    = v.rdata;
      exp_q.push_back(e);
    end
    tick();
    bus.addr   = v.addr;
    bus.rw     = v.rw;
    bus.data_i = v.wdata;
    bus.as_n   = 1'b0;
    bus.ds_n   = 1'b0;
    if (!hit) begin
      ok = 1'b1;
      repeat (12) begin
        tick();
        if (bus.reg_rd || bus.reg_wr || bus.data_oe || bus.dsack_n != 2'b11 || !bus.berr_n)
          ok = 1'b0;
      end
      chk("miss_quiet", 32'(ok), 32'd1);
    end else begin
      n = 0;
      while (!(bus.reg_rd || bus.reg_wr) && n < 10) begin tick(); n++; end
      chk("req_latency", n, 32'd3);
      chk("req_kind", 32'({bus.reg_rd, bus.reg_wr}), v.rw ? 32'd2 : 32'd1);
      if (v.ack_dly < 0) begin
        ok = 1'b1;
        n  = 0;
        while (bus.berr_n && n < 200) begin
          tick();
          n++;
          if (bus.dsack_n != 2'b11) ok = 1'b0;
        end
        chk("berr_latency", n, TIMEOUT);
        chk("berr_no_dsack", 32'(ok), 32'd1);
        chk("berr_req_drop", 32'(bus.reg_rd | bus.reg_wr), 32'd0);
      end else begin
        repeat (v.ack_dly) tick();
        bus.reg_rdata = v.rdata;
        bus.reg_ack   = 1'b1;
        n = 0;
        while (bus.dsack_n != 2'b00 && n < 20) begin
          tick();
          n++;
          if (n == 1) begin
            bus.reg_ack   = 1'b0;
            bus.reg_rdata = 32'hDEAD_BEEF;
            chk("req_drop_on_ack", 32'(bus.reg_rd | bus.reg_wr), 32'd0);
          end
        end
        chk("dsack_latency", n, 1 + DSACK_DELAY);
      end
    end
    bus.as_n = 1'b1;
    bus.ds_n = 1'b1;
    if (hit) begin
      n = 0;
      while ((bus.dsack_n != 2'b11 || !bus.berr_n || bus.data_oe) && n < 10) begin tick(); n++; end
      chk("release_latency", n, 32'd3);
    end else begin
      repeat (3) tick();
    end
    chk("idle_dsack", 32'(bus.dsack_n), 32'd3);
    chk("idle_berr", 32'(bus.berr_n), 32'd1);
    repeat (2) tick();
  endtask

  initial begin
    int   n;
    bit   ok;
    exp_t e;

    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{32'h00DD_0008, 1'b1, 32'h0000_0000, 32'hCAFE_F00D,  2};
    vecs[1] = '{32'h00DD_00FC, 1'b0, 32'h1234_5678, 32'h0000_0000,  1};
    vecs[2] = '{32'h00DE_0000, 1'b1, 32'h0000_0000, 32'h1111_1111,  0};
    vecs[3] = '{32'h00DD_0000, 1'b1, 32'h0000_0000, 32'h0000_0001,  0};
    vecs[4] = '{32'h00DD_0040, 1'b0, 32'hA5A5_5A5A, 32'h0000_0000,  5};
    vecs[5] = '{32'h00DD_0010, 1'b1, 32'h0000_0000, 32'h0000_0000, -1};
    vecs[6] = '{32'h00DD_00FC, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 63};
    vecs[7] = '{32'h10DD_0004, 1'b0, 32'h7777_7777, 32'h0000_0000,  0};
    vecs[8] = '{32'h00DD_0024, 1'b0, 32'h0000_0000, 32'h0000_0000, -1};

    rst_n         = 1'b0;
    bus.addr      = '0;
    bus.as_n      = 1'b1;
    bus.ds_n      = 1'b1;
    bus.rw        = 1'b1;
    bus.data_i    = '0;
    bus.reg_rdata = '0;
    bus.reg_ack   = 1'b0;
    repeat (3) tick();

    chk("rst_dsack",     32'(bus.dsack_n),  32'd3);
    chk("rst_berr",      32'(bus.berr_n),   32'd1);
    chk("rst_data_oe",   32'(bus.data_oe),  32'd0);
    chk("rst_data_o",    bus.data_o,        32'd0);
    chk("rst_reg_rd",    32'(bus.reg_rd),   32'd0);
    chk("rst_reg_wr",    32'(bus.reg_wr),   32'd0);
    chk("rst_reg_addr",  32'(bus.reg_addr), 32'd0);
    chk("rst_reg_wdata", bus.reg_wdata,     32'd0);

    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i]);
    end

    // Master abort while waiting for the backend
    bus.addr = 32'h00DD_0020;
    bus.rw   = 1'b1;
    bus.as_n = 1'b0;
    bus.ds_n = 1'b0;
    n = 0;
    while (!bus.reg_rd && n < 10) begin tick(); n++; end
    chk("abort_req_latency", n, 32'd3);
    repeat (5) tick();
    bus.as_n = 1'b1;
    bus.ds_n = 1'b1;
    n = 0;
    while (bus.reg_rd && n < 10) begin tick(); n++; end
    chk("abort_drop_latency", n, 32'd3);
    ok = 1'b1;
    repeat (TIMEOUT + 8) begin
      tick();
      if (bus.dsack_n != 2'b11 || !bus.berr_n || bus.data_oe || bus.reg_rd) ok = 1'b0;
    end
    chk("abort_quiet", 32'(ok), 32'd1);

    // Reset asserted while _DSACK is driven
    e.berr     = 1'b0;
    e.reg_addr = 6'd1;
    e.rw       = 1'b1;
    e.wdata    = '0;
    e.rdata    = 32'h0BAD_F00D;
    exp_q.push_back(e);
    bus.addr = 32'h00DD_0004;
    bus.rw   = 1'b1;
    bus.as_n = 1'b0;
    bus.ds_n = 1'b0;
    n = 0;
    while (!bus.reg_rd && n < 10) begin tick(); n++; end
    bus.reg_rdata = 32'h0BAD_F00D;
    bus.reg_ack   = 1'b1;
    tick();
    bus.reg_ack = 1'b0;
    n = 0;
    while (bus.dsack_n != 2'b00 && n < 10) begin tick(); n++; end
    chk("rst_term_dsack_seen", 32'(bus.dsack_n), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dsack",   32'(bus.dsack_n), 32'd3);
    chk("async_rst_data_oe", 32'(bus.data_oe), 32'd0);
    chk("async_rst_data_o",  bus.data_o,       32'd0);
    bus.as_n = 1'b1;
    bus.ds_n = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    run_vec(vecs[0]);
    run_vec(vecs[1]);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
